// File: rtl/store_buffer.sv
// Posted-write store buffer between the cpu data port and data_memory.
// Stores queue in a circular FIFO and retire on non-load cycles; loads forward from the youngest matching entry.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cpu_mem_read,
   input  logic             cpu_mem_write,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic [31:0]      cpu_rdata,
   output logic             cpu_stall,
   output logic             dm_mem_read,
   output logic             dm_mem_write,
   output logic [31:0]      dm_addr,
   output logic [31:0]      dm_wdata,
   input  logic [31:0]      dm_rdata,
   output logic [CNT_W-1:0] sb_count,
   output logic             sb_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef struct packed {
      logic [29:0] word_addr;
      logic [31:0] data;
   } entry_t;

   entry_t           entries [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [31:0]      last_addr;
   logic [31:0]      last_wdata;

   logic             load;
   logic             drain;
   logic             push;
   logic             hit;
   logic [31:0]      fwd_data;

   // Combinational outputs are gated by rst_n so they read as reset values while reset is held.
   assign load  = rst_n & cpu_mem_read;
   assign drain = ~cpu_mem_read & (count != '0);
   assign push  = cpu_mem_write & (count != FULL);

   // Scan oldest to youngest so the last match wins, which is the youngest store.
   always_comb begin
      // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
      hit      = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count) &&
             (entries[head + PTR_W'(i)].word_addr == cpu_addr[31:2])) begin
            hit      = 1'b1;
            fwd_data = entries[head + PTR_W'(i)].data;
         end
      end
   end

   always_comb begin
      dm_mem_read  = load;
      dm_mem_write = drain;
      dm_addr      = last_addr;
      dm_wdata     = last_wdata;
      if (load) begin
         dm_addr = cpu_addr;
      end else if (drain) begin
         dm_addr  = {entries[head].word_addr, 2'b00};
         dm_wdata = entries[head].data;
      end
      if (!rst_n)
         cpu_rdata = '0;
      else if (load && hit)
         cpu_rdata = fwd_data;
      else
         cpu_rdata = dm_rdata;
   end

   assign cpu_stall = cpu_mem_write & (count == FULL);
   assign sb_count  = count;
   assign sb_empty  = (count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         last_addr  <= '0;
         last_wdata <= '0;
      end else begin
         if (push)
            tail <= tail + 1'b1;
         if (drain)
            head <= head + 1'b1;
         if (push && !drain)
            count <= count + 1'b1;
         else if (drain && !push)
            count <= count - 1'b1;
         // Idle cycles drive these registers back out, so the bus holds its last value.
         last_addr  <= dm_addr;
         last_wdata <= dm_wdata;
      end
   end

   // NOTE: entry storage has no reset; count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (push)
         entries[tail] <= '{word_addr: cpu_addr[31:2], data: cpu_wdata};
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based program-order model checked every cycle,
// directed scenarios with literal expectations, then randomized load/store traffic.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cpu_mem_read;
   logic             cpu_mem_write;
   logic [31:0]      cpu_addr;
   logic [31:0]      cpu_wdata;
   logic [31:0]      cpu_rdata;
   logic             cpu_stall;
   logic             dm_mem_read;
   logic             dm_mem_write;
   logic [31:0]      dm_addr;
   logic [31:0]      dm_wdata;
   logic [31:0]      dm_rdata;
   logic [CNT_W-1:0] sb_count;
   logic             sb_empty;

   store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
      .sb_count(sb_count), .sb_empty(sb_empty)
   );

   always #5 clk = ~clk;

   // data_memory: 64 words, combinational read, written by the DUT.
   logic [31:0] mem [64] = '{default: '0};
   assign dm_rdata = mem[dm_addr[7:2]];
   always @(posedge clk) if (dm_mem_write) mem[dm_addr[7:2]] <= dm_wdata;

   // Reference: pending stores in program order plus the memory image they retire into.
   typedef struct {
      logic [29:0] wa;
      logic [31:0] data;
   } st_t;
   st_t         q[$];
   logic [31:0] ref_mem [64] = '{default: '0};
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] prog_value(input logic [31:0] a);
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].wa == a[31:2]) return q[i].data;
      return ref_mem[a[7:2]];
   endfunction

   function automatic logic [31:0] exp_addr();
      if (cpu_mem_read) return cpu_addr;
      if (q.size() != 0) return {q[0].wa, 2'b00};
      return m_addr;
   endfunction

   function automatic logic [31:0] exp_idle_rdata();
      logic [31:0] a;
      a = exp_addr();
      return ref_mem[a[7:2]];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_addr  <= '0;
         m_wdata <= '0;
      end else begin
         if (cpu_mem_read) m_addr <= cpu_addr;
         if (!cpu_mem_read && q.size() != 0) begin
            ref_mem[q[0].wa[5:0]] <= q[0].data;
            m_addr  <= {q[0].wa, 2'b00};
            m_wdata <= q[0].data;
            // Full is judged before the pop: after popping, room means pre-pop size < DEPTH.
            if (cpu_mem_write && q.size() < DEPTH) begin
               void'(q.pop_front());
               q.push_back('{cpu_addr[31:2], cpu_wdata});
            end else begin
               void'(q.pop_front());
            end
         end else if (cpu_mem_write && q.size() < DEPTH) begin
            q.push_back('{cpu_addr[31:2], cpu_wdata});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_sb_count", 32'(sb_count), 32'd0);
         check("rst_sb_empty", 32'(sb_empty), 32'd1);
         check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
         check("rst_dm_mem_read", 32'(dm_mem_read), 32'd0);
         check("rst_dm_mem_write", 32'(dm_mem_write), 32'd0);
         check("rst_dm_addr", dm_addr, 32'd0);
         check("rst_dm_wdata", dm_wdata, 32'd0);
         check("rst_cpu_rdata", cpu_rdata, 32'd0);
      end else begin
         check("sb_count", 32'(sb_count), 32'(q.size()));
         check("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
         check("cpu_stall", 32'(cpu_stall), 32'(cpu_mem_write && q.size() == DEPTH));
         check("dm_mem_read", 32'(dm_mem_read), 32'(cpu_mem_read));
         check("dm_mem_write", 32'(dm_mem_write), 32'(!cpu_mem_read && q.size() != 0));
         check("dm_addr", dm_addr, exp_addr());
         check("dm_wdata", dm_wdata, (!cpu_mem_read && q.size() != 0) ? q[0].data : m_wdata);
         check("cpu_rdata", cpu_rdata, cpu_mem_read ? prog_value(cpu_addr) : exp_idle_rdata());
      end
   end

   task automatic set_in(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      cpu_mem_read  = rd;
      cpu_mem_write = wr;
      cpu_addr      = a;
      cpu_wdata     = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_all();
      set_in(1'b0, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 20 && !sb_empty; i++) tick();
      check("drain_timeout", 32'(sb_empty), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      set_in(1'b0, 1'b0, 32'd0, 32'd0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Idle after reset: no memory activity.
      check("t1_empty", 32'(sb_empty), 32'd1);
      check("t1_count", 32'(sb_count), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t1_no_write", 32'(dm_mem_write), 32'd0);
         check("t1_no_read", 32'(dm_mem_read), 32'd0);
      end

      // Two stores drain in order.
      set_in(1'b0, 1'b1, 32'h0C, 32'd10); tick();
      set_in(1'b0, 1'b1, 32'h10, 32'd20); tick();
      set_in(1'b0, 1'b0, 32'h0, 32'h0);   tick();
      check("t2_mem3", mem[3], 32'd10);
      check("t2_mem4", mem[4], 32'd20);
      check("t2_empty", 32'(sb_empty), 32'd1);

      // Forwarding: loads hold off the drain, youngest duplicate wins.
      set_in(1'b1, 1'b1, 32'h14, 32'h55); tick();
      set_in(1'b1, 1'b1, 32'h14, 32'h66); #1;
      check("t3_fwd_pre_push", cpu_rdata, 32'h55);
      tick();
      set_in(1'b1, 1'b0, 32'h14, 32'h0); #1;
      check("t3_fwd_youngest", cpu_rdata, 32'h66);
      tick();
      drain_all();
      check("t3_mem5", mem[5], 32'h66);

      // Full and stall.
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, 1'b1, 32'h80 + 32'(4 * k), 32'(k + 1));
         tick();
      end
      check("t4_full_count", 32'(sb_count), 32'd4);
      set_in(1'b1, 1'b1, 32'h90, 32'd5); #1;
      check("t4_stall", 32'(cpu_stall), 32'd1);
      tick();
      check("t4_no_push", 32'(sb_count), 32'd4);
      set_in(1'b0, 1'b1, 32'h90, 32'd5); #1;
      check("t4_stall_during_drain", 32'(cpu_stall), 32'd1);
      check("t4_drain", 32'(dm_mem_write), 32'd1);
      tick();
      check("t4_after_drain", 32'(cpu_stall), 32'd0);
      tick();
      drain_all();
      for (int k = 0; k < 5; k++) check("t4_mem", mem[32 + k], 32'(k + 1));

      // Wrap-around: store/load pairs keep one entry resident while pointers advance.
      for (int k = 0; k < 10; k++) begin
         set_in(1'b0, 1'b1, 32'(4 * k), 32'h100 + 32'(k)); tick();
         set_in(1'b1, 1'b0, 32'(4 * k), 32'h0); #1;
         check("t5_fwd", cpu_rdata, 32'h100 + 32'(k));
         tick();
      end
      set_in(1'b1, 1'b1, 32'h08, 32'hA); tick();
      set_in(1'b1, 1'b1, 32'h08, 32'hB); tick();
      set_in(1'b1, 1'b1, 32'h08, 32'hC); tick();
      set_in(1'b1, 1'b0, 32'h0B, 32'h0); #1;
      check("t5_fwd_wrap", cpu_rdata, 32'hC);
      tick();
      drain_all();
      check("t5_mem9", mem[9], 32'h109);
      check("t5_mem2", mem[2], 32'hC);

      // Randomized traffic over a small address window to force frequent matches.
      for (int n = 0; n < 3000; n++) begin
         set_in($urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
                {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))}, $urandom);
         tick();
      end
      drain_all();
      for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

      // Reset mid-cycle discards buffered stores.
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, 1'b1, 32'hE0 + 32'(4 * k), 32'hDEAD0 + 32'(k));
         tick();
      end
      set_in(1'b1, 1'b0, 32'hE0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_count", 32'(sb_count), 32'd0);
      check("t6_empty", 32'(sb_empty), 32'd1);
      check("t6_rd", 32'(dm_mem_read), 32'd0);
      check("t6_rdata", cpu_rdata, 32'd0);
      check("t6_addr", dm_addr, 32'd0);
      set_in(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_no_write", 32'(dm_mem_write), 32'd0);
      end
      for (int k = 0; k < 3; k++) check("t6_mem_untouched", mem[56 + k], 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
